// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one uart_tx byte transmitter between NUM_REQ requesters. Each grant
// carries one byte, and the requester after the previous winner has priority.
// A byte sent with req_last=0 locks the transmitter to its requester until
// that requester sends a byte with req_last=1, or until the requester stays
// idle for LOCK_TIMEOUT cycles.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   req_valid/data/last/ready
//                   per-lane byte handshake; lane i uses req_data[8i+7:8i]
//   tx_data, tx_data_valid, tx_data_ready
//                   transmitter side; tx_data_valid is a one-cycle launch
//                   strobe, and tx_data_ready is high while the transmitter
//                   is idle
//   busy            a byte is in flight
//   grant_id        owner of the current or the last transfer
//   locked          the packet lock is held by grant_id
//   byte_cnt        bytes launched since reset; wraps from 0xFFFF to 0
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_data_valid,
  input  logic                 tx_data_ready,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 locked,
  output logic [15:0]          byte_cnt
);

  localparam int TO_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_ACK    = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [7:0]          tx_data_r;
  logic                tx_valid_r;
  logic [ID_W-1:0]     grant_id_r;
  logic                locked_r;
  logic [15:0]         byte_cnt_r;
  logic [TO_W-1:0]     to_cnt_r;

  logic                found_s;
  logic [ID_W-1:0]     sel_s;
  logic [ID_W-1:0]     idx_s;
  int                  rot_s;
  logic                grant_s;
  logic [NUM_REQ-1:0]  ready_s;
  logic                to_count_s;
  logic                to_expire_s;

  // Lane selection. The search starts after the last owner, so the last
  // owner gets the lowest priority. A held lock admits only its owner.
  always_comb begin
    found_s = 1'b0;
    sel_s   = grant_id_r;
    idx_s   = grant_id_r;
    rot_s   = 0;
    if (locked_r) begin
      found_s = req_valid[grant_id_r];
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        rot_s = (int'(grant_id_r) + k) % NUM_REQ;
        idx_s = ID_W'(rot_s);
        if (!found_s && req_valid[idx_s]) begin
          found_s = 1'b1;
          sel_s   = idx_s;
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // The grant is purely combinational, so a request is accepted in the cycle
  // it is presented. Gating on rst_n keeps req_ready low while in reset.
  assign grant_s = rst_n & (state_r == S_IDLE) & tx_data_ready & found_s;

  // Lock-timeout conditions: the owner leaves its request low while idle.
  assign to_count_s  = (state_r == S_IDLE) & locked_r & ~req_valid[grant_id_r];
  assign to_expire_s = to_count_s & (to_cnt_r == TO_MAX);

  // One-hot accept strobe for the selected lane.
  always_comb begin
    ready_s = {NUM_REQ{1'b0}};
    if (grant_s) begin
      ready_s[sel_s] = 1'b1;
    end else begin
      ready_s = {NUM_REQ{1'b0}};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state. The ACK state waits for the transmitter to drop ready, so a
  // transmitter that is slow to start cannot be mistaken for one that is done.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:   if (grant_s)        state_s = S_LAUNCH; else state_s = S_IDLE;
      S_LAUNCH:                     state_s = S_ACK;
      S_ACK:    if (!tx_data_ready) state_s = S_WAIT;   else state_s = S_ACK;
      S_WAIT:   if (tx_data_ready)  state_s = S_IDLE;   else state_s = S_WAIT;
      default:                      state_s = S_IDLE;
    endcase
  end

  // Datapath: launch register, owner, lock, byte counter and lock timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_r  <= 8'd0;
      tx_valid_r <= 1'b0;
      grant_id_r <= {ID_W{1'b0}};
      locked_r   <= 1'b0;
      byte_cnt_r <= 16'd0;
      to_cnt_r   <= {TO_W{1'b0}};
    end else if (grant_s) begin
      tx_data_r  <= req_data[{sel_s, 3'b000} +: 8];
      tx_valid_r <= 1'b1;
      grant_id_r <= sel_s;
      locked_r   <= ~req_last[sel_s];
      byte_cnt_r <= byte_cnt_r + 16'd1;
      to_cnt_r   <= {TO_W{1'b0}};
    end else begin
      tx_valid_r <= 1'b0;
      if (to_expire_s) begin
        locked_r <= 1'b0;
        to_cnt_r <= {TO_W{1'b0}};
      end else if (!locked_r) begin
        to_cnt_r <= {TO_W{1'b0}};
      end else if (to_count_s) begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
    end
  end

  assign req_ready     = ready_s;
  assign tx_data       = tx_data_r;
  assign tx_data_valid = tx_valid_r;
  assign busy          = (state_r != S_IDLE);
  assign grant_id      = grant_id_r;
  assign locked        = locked_r;
  assign byte_cnt      = byte_cnt_r;

endmodule
